// File: rtl/prp_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : prp_mem_responder
// Brief    : Peripheral-bus memory responder with a registered fetch port and a
//            wait-stated, size-aware load/store port over on-chip RAM.
// Revision : 1.0
// ============================================================================
module prp_mem_responder #(
    parameter int          DEPTH    = 1024,
    parameter int          ADDR_W   = 32,
    parameter int          WAIT_CYC = 1,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] prp_inst_addr,
    output logic [31:0]       prp_inst,
    input  logic              prp_re,
    input  logic              prp_we,
    input  logic [ADDR_W-1:0] prp_addr,
    input  logic [31:0]       prp_wdata,
    input  logic [2:0]        prp_byte_sel,
    output logic [31:0]       prp_rdata,
    output logic              prp_ready,
    output logic              prp_err
);
    localparam int         c_IW   = $clog2(DEPTH);
    localparam logic [3:0] c_WAIT = 4'(WAIT_CYC);
    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_BUSY = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [31:0]       r_mem [DEPTH];
    logic [1:0]        r_state;
    logic [1:0]        w_next_state;
    logic [3:0]        r_cnt;
    logic              r_re;
    logic              r_we;
    logic              r_err;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [2:0]        r_sel;

    logic              w_idle;
    logic              w_req;
    logic              w_re;
    logic              w_we;
    logic [ADDR_W-1:0] w_addr;
    logic [31:0]       w_wdata;
    logic [2:0]        w_sel;
    logic [c_IW-1:0]   w_idx;
    logic [c_IW-1:0]   w_f_idx;
    logic              w_d_oor;
    logic              w_f_oor;
    logic              w_sel_ok;
    logic              w_misalign;
    logic              w_err;
    logic              w_enter_done;
    logic              w_commit;
    logic [31:0]       w_word;
    logic [15:0]       w_half;
    logic [7:0]        w_byte;
    logic [31:0]       w_load;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata_al;

    // With zero wait states the access commits on its sampling edge, so in
    // IDLE the live inputs stand in for the not-yet-latched copies.
    assign w_idle  = (r_state == c_IDLE);
    assign w_req   = prp_re | prp_we;
    assign w_re    = w_idle ? prp_re       : r_re;
    assign w_we    = w_idle ? prp_we       : r_we;
    assign w_addr  = w_idle ? prp_addr     : r_addr;
    assign w_wdata = w_idle ? prp_wdata    : r_wdata;
    assign w_sel   = w_idle ? prp_byte_sel : r_sel;

    assign w_idx   = w_addr[c_IW+1:2];
    assign w_f_idx = prp_inst_addr[c_IW+1:2];

    generate
        if (ADDR_W > c_IW + 2) begin : g_oor
            assign w_d_oor = |w_addr[ADDR_W-1:c_IW+2];
            assign w_f_oor = |prp_inst_addr[ADDR_W-1:c_IW+2];
        end else begin : g_no_oor
            assign w_d_oor = 1'b0;
            assign w_f_oor = 1'b0;
        end
    endgenerate

    assign w_sel_ok   = (w_sel == 3'b000) || (w_sel == 3'b001) || (w_sel == 3'b010) ||
                        (w_sel == 3'b100) || (w_sel == 3'b101);
    assign w_misalign = ((w_sel[1:0] == 2'b01) && w_addr[0]) ||
                        ((w_sel[1:0] == 2'b10) && (w_addr[1:0] != 2'b00));
    assign w_err      = (w_re & w_we) | w_d_oor | w_misalign | ~w_sel_ok;

    assign w_enter_done = (w_next_state == c_DONE);
    assign w_commit     = w_enter_done & w_we & ~w_err & rst;

    assign w_word = r_mem[w_idx];
    assign w_half = w_addr[1] ? w_word[31:16] : w_word[15:0];
    assign w_byte = w_addr[0] ? w_half[15:8]  : w_half[7:0];

    always_comb begin
        case (w_sel)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b100:  w_load = {24'b0, w_byte};
            3'b101:  w_load = {16'b0, w_half};
            default: w_load = w_word;
        endcase
    end

    always_comb begin
        case (w_sel[1:0])
            2'b00: begin
                w_be       = 4'b0001 << w_addr[1:0];
                w_wdata_al = {4{w_wdata[7:0]}};
            end
            2'b01: begin
                w_be       = w_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata_al = {2{w_wdata[15:0]}};
            end
            default: begin
                w_be       = 4'b1111;
                w_wdata_al = w_wdata;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_commit) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata_al[8*b +: 8];
            end
        end
    end

    // Fetch reads the pre-write contents, giving read-first behaviour.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prp_inst <= NOP_INST;
        end else if (!w_f_oor && (prp_inst_addr[1:0] == 2'b00)) begin
            prp_inst <= r_mem[w_f_idx];
        end else begin
            prp_inst <= NOP_INST;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= c_IDLE;
            r_cnt     <= 4'd0;
            r_re      <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= 32'd0;
            r_sel     <= 3'd0;
            r_err     <= 1'b0;
            prp_rdata <= 32'd0;
        end else begin
            r_state <= w_next_state;
            if (w_idle && w_req) begin
                r_re    <= prp_re;
                r_we    <= prp_we;
                r_addr  <= prp_addr;
                r_wdata <= prp_wdata;
                r_sel   <= prp_byte_sel;
                r_cnt   <= c_WAIT;
            end else if (r_state == c_BUSY) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_enter_done) begin
                r_err     <= w_err;
                prp_rdata <= w_err ? 32'd0 : w_load;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:  if (w_req) w_next_state = (c_WAIT == 4'd0) ? c_DONE : c_BUSY;
            c_BUSY:  if (r_cnt == 4'd1) w_next_state = c_DONE;
            c_DONE:  w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    always_comb begin
        prp_ready = (r_state == c_DONE);
        prp_err   = (r_state == c_DONE) & r_err;
    end
endmodule
`default_nettype wire

// File: doc/prp_mem_responder.md
Name: prp_mem_responder

Overview:
Memory-side responder for the core's peripheral bus (the prp_* signals). It serves instruction fetches on a registered read port. It also serves data loads and stores through a request/ready handshake with configurable wait states, byte/halfword/word sizing, sign/zero extension and error signalling. It sits outside the core, between the core top level and the on-chip RAM array, which is held inside this block.

Parameters:
DEPTH, 1024, number of 32-bit words in the RAM array (power of two)
ADDR_W, 32, width of prp_inst_addr and prp_addr (byte addresses)
WAIT_CYC, 1, wait-state cycles inserted before a data access completes (0..15)
NOP_INST, 32'h00000013, instruction returned for out-of-range fetches and after reset

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-low
prp_inst_addr  input  ADDR_W  instruction fetch byte address
prp_inst  output  32  fetched instruction, registered
prp_re  input  1  data read request, held by the core until prp_ready
prp_we  input  1  data write request, held by the core until prp_ready
prp_addr  input  ADDR_W  data byte address
prp_wdata  input  32  store data, right-aligned
prp_byte_sel  input  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
prp_rdata  output  32  load data, extended and right-aligned
prp_ready  output  1  one-cycle completion pulse
prp_err  output  1  one-cycle error pulse, coincident with prp_ready

Behaviour:
- Reset (rst=0, asynchronous): prp_inst=NOP_INST; prp_rdata=0; prp_ready=0; prp_err=0; FSM=IDLE; wait counter=0. RAM contents are not reset.
- Reset asserted mid-access aborts the access. No RAM write occurs and no ready pulse is issued.
- Word index = addr[log2(DEPTH)+1:2]. An address is out of range if addr >= 4*DEPTH.
- Fetch port behaviour:
  - prp_inst is updated every cycle from prp_inst_addr, with 1-cycle latency.
  - Out-of-range or non-word-aligned fetch addresses return NOP_INST.
  - Fetch and data write to the same word in the same cycle is read-first: the fetch returns the old word.
- Data FSM states:
  - IDLE: a request is sampled when prp_re|prp_we=1. Address, data, byte_sel and direction are latched. Next state is BUSY with counter=WAIT_CYC if WAIT_CYC>0, otherwise DONE.
  - BUSY: the counter decrements each cycle. Move to DONE when the counter reaches 1.
  - DONE: prp_ready=1 for exactly this cycle; unconditionally return to IDLE.
  - Latency: a request sampled at edge N gives prp_ready high during cycle N+1+WAIT_CYC.
- Write commit:
  - The RAM write happens on the edge entering DONE, masked by size.
  - B writes byte addr[1:0] with wdata[7:0].
  - H writes half addr[1] with wdata[15:0].
  - W writes the full word.
- Load data:
  - prp_rdata is valid only in the DONE cycle and holds its value until the next DONE.
  - B/H sign-extend; BU/HU zero-extend; W is passed unchanged.
- Error conditions:
  - Conditions: prp_re and prp_we both set; address out of range; misaligned access (H with addr[0]=1, W with addr[1:0]!=0); byte_sel not in the legal set.
  - Effect: access proceeds through the same timing, but there is no RAM write and prp_rdata=0. prp_err=1 together with prp_ready.
- Handshake rules:
  - Inputs are ignored outside IDLE. The latched values are used even if the core changes them.
  - A request still asserted in the cycle after DONE is treated as a new access.
  - Back-to-back accesses give one ready pulse every WAIT_CYC+2 cycles.

Test Plan:
- Reset mid-access: rst low during BUSY of SW 0xDEADBEEF to 0x10 -> no ready pulse; later LW 0x10 returns the prior contents; after release prp_inst=0x00000013, ready=0, err=0.
- Word store/load, WAIT_CYC=1: SW 0xDEADBEEF to 0x10 -> ready at cycle N+2, err=0; LW 0x10 -> rdata 0xDEADBEEF.
- Sub-word store/load: SB 0x80 to 0x13, then LB 0x13 -> 0xFFFFFF80; LBU 0x13 -> 0x00000080; LW 0x10 -> 0x80ADBEEF.
- Halfword: SH 0x8001 to 0x22, then LH 0x22 -> 0xFFFF8001 and LHU 0x22 -> 0x00008001; SH to 0x21 -> err=1, word at 0x20 unchanged.
- Error cases: re and we both high -> err=1, no write; LW at 4*DEPTH -> err=1, rdata 0.
- Fetch port: inst_addr 0x10 after the SW above -> prp_inst 0xDEADBEEF next cycle; inst_addr 0x4002 -> 0x00000013; SW to 0x10 with a same-cycle fetch of 0x10 -> old value returned.
- Back-to-back, WAIT_CYC=0: re held high continuously -> ready pulses every 2 cycles, with rdata updated on each pulse.
